// File: rtl/uart_mem_streamer_pkg.sv
// Shared types for the memory-to-UART streamer: FSM states, parity modes
// and the parity helper used when a byte is loaded.
package uart_mem_streamer_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DELAY,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_GAP,
        S_FIN
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // XOR of the low nbits of data; inverted for odd parity.
    function automatic logic parity_bit(input logic [7:0] data, input int nbits, input int mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < nbits) p = p ^ data[i];
        end
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_mem_streamer_bit_timer.sv
// Bit-period timer: free-running modulo-BT counter with a one-cycle tick on
// the last cycle of each period; restart realigns it to a fresh period.
module uart_bit_timer #(
    parameter int BT = 870
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = (BT > 2) ? $clog2(BT) : 1;
    localparam logic [CW-1:0] LAST = CW'(BT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_mem_streamer.sv
// Streams a block of bytes from a synchronous-read memory out of a UART
// transmitter, with a start delay, inter-frame gaps and frame-boundary abort.
module uart_mem_streamer
    import uart_mem_streamer_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 435,
    parameter int ADDR_W           = 32,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int GAP_CYCLES       = 1000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_length,
    input  logic [31:0]       i_delay,
    input  logic              i_abort,
    output logic [ADDR_W-1:0] o_ra,
    input  logic [7:0]        i_rd,
    output logic              o_txd,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_sent
);

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_mem_streamer: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_mem_streamer: STOP_BITS must be 1..2");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
        $error("uart_mem_streamer: PARITY must be 0..2");
    end
    if (CLK_PER_HALF_BIT < 1) begin : g_bad_baud
        $error("uart_mem_streamer: CLK_PER_HALF_BIT must be >= 1");
    end

    localparam int         BT        = 2 * CLK_PER_HALF_BIT;
    localparam logic [7:0] DMASK     = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_ra;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_sent;
    logic [31:0]       r_dly;
    logic [7:0]        r_shift;
    logic              r_par;
    logic [2:0]        r_bitn;
    logic              r_abort;
    logic              r_done;

    logic w_tick;
    logic w_restart;
    logic w_abort;
    logic w_last_frame;
    logic w_txd;

    assign w_abort      = r_abort | i_abort;
    assign w_last_frame = ((r_sent + ADDR_W'(1)) == r_len);
    // Every state change starts a fresh bit period, so frames never drift.
    assign w_restart    = (w_next != r_state);

    uart_bit_timer #(.BT(BT)) u_bit_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_length == '0)      w_next = S_FIN;
                    else if (i_delay == '0)  w_next = S_FETCH;
                    else                     w_next = S_DELAY;
                end
            end
            S_DELAY: begin
                if (w_abort)                 w_next = S_FIN;
                else if (r_dly == 32'd1)     w_next = S_FETCH;
            end
            S_FETCH: w_next = S_LOAD;
            S_LOAD:  w_next = S_START;
            S_START: begin
                if (w_tick) w_next = S_DATA;
            end
            S_DATA: begin
                if (w_tick && r_bitn == DATA_LAST) begin
                    w_next = (PARITY != PAR_NONE) ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (w_tick) w_next = S_STOP;
            end
            S_STOP: begin
                if (w_tick && r_bitn == STOP_LAST) begin
                    if (w_last_frame || w_abort) w_next = S_FIN;
                    else if (GAP_CYCLES == 0)    w_next = S_FETCH;
                    else                         w_next = S_GAP;
                end
            end
            S_GAP: begin
                if (w_abort)                 w_next = S_FIN;
                else if (r_dly == 32'd1)     w_next = S_FETCH;
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ra    <= '0;
            r_len   <= '0;
            r_sent  <= '0;
            r_dly   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_bitn  <= '0;
            r_abort <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_FIN);

            if (r_state == S_FIN)                        r_abort <= 1'b0;
            else if (r_state != S_IDLE && i_abort)       r_abort <= 1'b1;

            if (w_restart)                               r_bitn <= '0;
            else if (w_tick && (r_state == S_DATA || r_state == S_STOP))
                                                         r_bitn <= r_bitn + 3'd1;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_ra   <= i_base_addr;
                        r_len  <= i_length;
                        r_sent <= '0;
                        r_dly  <= i_delay;
                    end
                end
                S_DELAY, S_GAP: r_dly <= r_dly - 32'd1;
                S_LOAD: begin
                    r_shift <= i_rd & DMASK;
                    r_par   <= parity_bit(i_rd, DATA_BITS, PARITY);
                    r_ra    <= r_ra + ADDR_W'(1);
                end
                S_DATA: begin
                    if (w_tick) r_shift <= {1'b0, r_shift[7:1]};
                end
                S_STOP: begin
                    if (w_tick && r_bitn == STOP_LAST) begin
                        r_sent <= r_sent + ADDR_W'(1);
                        r_dly  <= 32'(GAP_CYCLES);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_txd = 1'b1;
        case (r_state)
            S_START: w_txd = 1'b0;
            S_DATA:  w_txd = r_shift[0];
            S_PAR:   w_txd = r_par;
            default: w_txd = 1'b1;
        endcase
    end

    assign o_txd  = w_txd;
    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;
    assign o_ra   = r_ra;
    assign o_sent = r_sent;

endmodule

// File: tb/tb_uart_mem_streamer.sv
// Directed bench: three streamers (8N1, 7E2, 7O2) at BT=8, GAP_CYCLES=3,
// fed by a one-cycle-latency memory; frames are decoded bit by bit off txd.
module tb_uart_mem_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start_e, start_o;
    logic [31:0] base, len, dly;
    logic        abort;

    logic [31:0] ra0, ra_e, ra_o, sent0, sent_e, sent_o;
    logic [7:0]  rd0, rd_e, rd_o;
    logic        txd0, txd_e, txd_o, busy0, busy_e, busy_o, done0, done_e, done_o;

    logic [7:0]  mem [0:255];
    int          errors = 0;
    int          checks = 0;
    int          dcnt0  = 0;
    int          dsnap;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd0 <= mem[ra0[7:0]];
        rd_e <= mem[ra_e[7:0]];
        rd_o <= mem[ra_o[7:0]];
        if (done0) dcnt0 <= dcnt0 + 1;
    end

    uart_mem_streamer #(.CLK_PER_HALF_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .GAP_CYCLES(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start0), .i_base_addr(base), .i_length(len),
        .i_delay(dly), .i_abort(abort), .o_ra(ra0), .i_rd(rd0), .o_txd(txd0),
        .o_busy(busy0), .o_done(done0), .o_sent(sent0));

    uart_mem_streamer #(.CLK_PER_HALF_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .GAP_CYCLES(3)) dut_e (
        .i_clk(clk), .i_rst(rst), .i_start(start_e), .i_base_addr(base), .i_length(len),
        .i_delay(dly), .i_abort(1'b0), .o_ra(ra_e), .i_rd(rd_e), .o_txd(txd_e),
        .o_busy(busy_e), .o_done(done_e), .o_sent(sent_e));

    uart_mem_streamer #(.CLK_PER_HALF_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .GAP_CYCLES(3)) dut_o (
        .i_clk(clk), .i_rst(rst), .i_start(start_o), .i_base_addr(base), .i_length(len),
        .i_delay(dly), .i_abort(1'b0), .o_ra(ra_o), .i_rd(rd_o), .o_txd(txd_o),
        .o_busy(busy_o), .o_done(done_o), .o_sent(sent_o));

    function automatic logic txd_of(input int w);
        return (w == 0) ? txd0 : (w == 1) ? txd_e : txd_o;
    endfunction
    function automatic logic done_of(input int w);
        return (w == 0) ? done0 : (w == 1) ? done_e : done_o;
    endfunction
    function automatic logic busy_of(input int w);
        return (w == 0) ? busy0 : (w == 1) ? busy_e : busy_o;
    endfunction
    function automatic logic [31:0] sent_of(input int w);
        return (w == 0) ? sent0 : (w == 1) ? sent_e : sent_o;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle start pulse; returns at the negedge right after the accept edge.
    task automatic pulse(input int w);
        @(negedge clk);
        if (w == 0) start0 = 1'b1; else if (w == 1) start_e = 1'b1; else start_o = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start_e = 1'b0; start_o = 1'b0;
    endtask

    // Waits (bounded) for the start bit, checks the wait length, then checks
    // every bit at offsets 1 and 7 of its 8-cycle slot. Returns at offset 7
    // of the last stop bit. abort_bit pulses abort during that bit slot.
    task automatic rx_frame(input int w, input logic [7:0] b, input int nbits, input int pmode,
                            input int nstop, input int exp_wait, input int abort_bit);
        int   n;
        int   total;
        logic p;
        logic e;
        n = 0;
        while (txd_of(w) === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("w%0d_start_wait", w), n, exp_wait);
        p = 1'b0;
        for (int i = 0; i < nbits; i++) p = p ^ b[i];
        if (pmode == 2) p = ~p;
        total = 1 + nbits + ((pmode != 0) ? 1 : 0) + nstop;
        for (int k = 0; k < total; k++) begin
            if (k == 0)                          e = 1'b0;
            else if (k <= nbits)                 e = b[k-1];
            else if (pmode != 0 && k == nbits+1) e = p;
            else                                 e = 1'b1;
            repeat ((k == 0) ? 1 : 2) @(negedge clk);
            check($sformatf("w%0d_bit%0d_head", w, k), txd_of(w), e);
            if (k == abort_bit) abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            repeat (5) @(negedge clk);
            check($sformatf("w%0d_bit%0d_tail", w, k), txd_of(w), e);
        end
    endtask

    // From offset 7 of the final stop bit: FIN cycle, then the done cycle.
    task automatic finish(input int w, input logic [31:0] exp_sent);
        @(negedge clk);
        check($sformatf("w%0d_fin_done", w), done_of(w), 1'b0);
        check($sformatf("w%0d_fin_busy", w), busy_of(w), 1'b1);
        @(negedge clk);
        check($sformatf("w%0d_done", w), done_of(w), 1'b1);
        check($sformatf("w%0d_idle", w), busy_of(w), 1'b0);
        check($sformatf("w%0d_sent", w), sent_of(w), exp_sent);
        @(negedge clk);
        check($sformatf("w%0d_done_clr", w), done_of(w), 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start0 = 1'b0; start_e = 1'b0; start_o = 1'b0;
        abort = 1'b0; base = '0; len = '0; dly = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h20] = 8'h55;
        mem[8'h10] = 8'hA3; mem[8'h11] = 8'h3C; mem[8'h12] = 8'h81;
        mem[8'h40] = 8'h07;
        mem[8'h30] = 8'h12; mem[8'h31] = 8'h34; mem[8'h32] = 8'h56;
        mem[8'h33] = 8'h78; mem[8'h34] = 8'h9A;
        mem[8'h50] = 8'hC6;
        mem[8'hFF] = 8'h9A; mem[8'h00] = 8'h65;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd", txd0, 1'b1);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_sent", sent0, 32'd0);
        check("rst_ra", ra0, 32'd0);
        rst = 1'b0;

        // Single 0x55 frame, no delay: 0,1,0,1,0,1,0,1,0,1
        base = 32'h20; len = 32'd1; dly = 32'd0;
        dsnap = dcnt0;
        pulse(0);
        rx_frame(0, 8'h55, 8, 0, 1, 2, -1);
        finish(0, 32'd1);
        check("a_done_count", dcnt0, dsnap + 1);

        // Three frames from 0x10 with delay 4; gaps are 3 GAP + FETCH + LOAD
        base = 32'h10; len = 32'd3; dly = 32'd4;
        dsnap = dcnt0;
        pulse(0);
        rx_frame(0, 8'hA3, 8, 0, 1, 6, -1);
        rx_frame(0, 8'h3C, 8, 0, 1, 6, -1);
        rx_frame(0, 8'h81, 8, 0, 1, 6, -1);
        finish(0, 32'd3);
        check("b_ra_end", ra0, 32'h13);
        check("b_done_count", dcnt0, dsnap + 1);

        // 7-bit 0x07: even parity bit 1, odd parity bit 0, two stop bits
        base = 32'h40; len = 32'd1; dly = 32'd0;
        pulse(1);
        rx_frame(1, 8'h07, 7, 1, 2, 2, -1);
        finish(1, 32'd1);
        pulse(2);
        rx_frame(2, 8'h07, 7, 2, 2, 2, -1);
        finish(2, 32'd1);

        // Zero length: FIN right after accept, done the cycle after, no frame
        base = 32'h20; len = 32'd0; dly = 32'd7;
        dsnap = dcnt0;
        pulse(0);
        check("z_fin_busy", busy0, 1'b1);
        check("z_fin_txd", txd0, 1'b1);
        check("z_fin_done", done0, 1'b0);
        @(negedge clk);
        check("z_done", done0, 1'b1);
        check("z_sent", sent0, 32'd0);
        check("z_txd", txd0, 1'b1);
        @(negedge clk);
        check("z_done_count", dcnt0, dsnap + 1);

        // Length 5, abort during frame 2 data bit 2: frame 2 completes, sent=2
        base = 32'h30; len = 32'd5; dly = 32'd0;
        pulse(0);
        rx_frame(0, 8'h12, 8, 0, 1, 2, -1);
        rx_frame(0, 8'h34, 8, 0, 1, 6, 3);
        finish(0, 32'd2);
        check("e_ra_end", ra0, 32'h32);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (txd0 !== 1'b1 || busy0 !== 1'b0) n++;
        end
        check("e_line_quiet", n, 0);

        // Reset in the middle of data bit 1 (a zero) of 0x55
        base = 32'h20; len = 32'd2; dly = 32'd0;
        pulse(0);
        n = 0;
        while (txd0 === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("f_start_seen", n, 2);
        repeat (18) @(negedge clk);
        check("f_mid_data", txd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("f_rst_txd", txd0, 1'b1);
        check("f_rst_busy", busy0, 1'b0);
        check("f_rst_sent", sent0, 32'd0);
        rst = 1'b0;
        base = 32'h50; len = 32'd1; dly = 32'd0;
        pulse(0);
        rx_frame(0, 8'hC6, 8, 0, 1, 2, -1);
        finish(0, 32'd1);

        // Address wrap from 0xFFFFFFFF
        base = 32'hFFFF_FFFF; len = 32'd2; dly = 32'd0;
        pulse(0);
        rx_frame(0, 8'h9A, 8, 0, 1, 2, -1);
        rx_frame(0, 8'h65, 8, 0, 1, 6, -1);
        finish(0, 32'd2);
        check("g_ra_wrap", ra0, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_mem_streamer.md
UART_MEM_STREAMER -- requirements
Module: uart_mem_streamer

Interface
REQ-001 Parameter CLK_PER_HALF_BIT, default 435, half bit period in clk cycles (115200 bit/s); bit time BT = 2*CLK_PER_HALF_BIT.
REQ-002 Parameter ADDR_W, default 32, memory address and length width.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame, legal 5..8.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, default 1, stop bits per frame, legal 1..2.
REQ-006 Parameter GAP_CYCLES, default 1000, idle-high cycles inserted between frames.
REQ-007 clk  in  1  single clock; all logic on its rising edge.
REQ-008 rst  in  1  reset, synchronous and active-high.
REQ-009 start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-010 base_addr  in  ADDR_W  first byte address; captured on accepted start.
REQ-011 length  in  ADDR_W  byte count; captured on accepted start.
REQ-012 delay  in  32  cycles of line-idle before the first frame; captured on accepted start.
REQ-013 abort  in  1  stop the transfer at the end of the current frame.
REQ-014 ra  out  ADDR_W  memory read address.
REQ-015 rd  in  8  memory read data, valid exactly one cycle after ra changes.
REQ-016 txd  out  1  serial line, idle high, LSB first.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse when a transfer ends (normal or aborted).
REQ-019 sent  out  ADDR_W  count of complete frames sent in the current or last transfer.

Function
REQ-020 States: IDLE, DELAY, FETCH, LOAD, START, DATA, PAR, STOP, GAP, FIN.
REQ-021 IDLE + start: capture inputs, ra<=base_addr, sent<=0, go DELAY; start in any other state is ignored.
REQ-022 DELAY holds txd=1 for exactly `delay` cycles (0 means zero cycles), then FETCH.
REQ-023 If captured length==0, DELAY is skipped and FIN follows the accept cycle; no frame is sent.
REQ-024 FETCH waits one cycle for rd; LOAD latches rd[DATA_BITS-1:0] into shift register, computes parity, increments ra.
REQ-025 START drives txd=0 for BT cycles; DATA shifts out DATA_BITS bits, BT cycles each, LSB first.
REQ-026 PAR (only if PARITY!=0) drives XOR of data bits (even) or its complement (odd) for BT cycles.
REQ-027 STOP drives txd=1 for STOP_BITS*BT cycles, then sent increments by 1.
REQ-028 After STOP: if sent==length or abort latched, go FIN; else GAP.
REQ-029 GAP holds txd=1 for GAP_CYCLES cycles, then FETCH; GAP_CYCLES=0 means FETCH directly.
REQ-030 abort in any busy state is latched; frames in progress complete intact; DELAY/GAP with abort go straight to FIN.
REQ-031 FIN pulses done for one cycle, clears the abort latch, returns to IDLE.
REQ-032 ra wraps modulo 2^ADDR_W without error.
REQ-033 Bit timing counter restarts at every state change; no accumulated drift across frames.
REQ-034 Simultaneous start and abort in IDLE: start accepted, abort ignored.

Reset
REQ-035 On rst: state IDLE, txd=1, busy=0, done=0, sent=0, ra=0, abort latch cleared, counters 0.
REQ-036 rst mid-frame forces txd=1 on the next cycle; no partial frame resumes.

Structure
REQ-037 Shared package holds the state enumeration and PARITY mode constants (NONE, EVEN, ODD).
REQ-038 One sub-module, uart_bit_timer: counter with restart input, emitting a one-cycle tick every BT cycles.
REQ-039 Illegal DATA_BITS or STOP_BITS values fail at elaboration.

Verification (CLK_PER_HALF_BIT=4, BT=8, GAP_CYCLES=3)
REQ-040 length=1, delay=0, rd=0x55, 8N1 -> txd 0,1,0,1,0,1,0,1,0,1 each 8 cycles; done once; sent=1.
REQ-041 length=3, base_addr=0x10 -> ra 0x10,0x11,0x12; 3-cycle idle gaps; done after third stop bit.
REQ-042 PARITY=1, DATA_BITS=7, rd=0x07 -> parity bit 1; PARITY=2 -> 0; 2 stop bits last 16 cycles.
REQ-043 length=0 -> no txd low, done pulse 2 cycles after start, sent=0.
REQ-044 length=5, abort during frame 2 data bits -> frame 2 completes, done pulses, sent=2.
REQ-045 rst asserted mid-DATA -> txd=1 next cycle, busy=0; new start then sends normally.
